vram_arbiter: RTL
=================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter REFRESH_INTERVAL, default 1620, meaning clocks between refresh requests (15 us at 108 MHz).
REQ-002 SHALL have parameter START_TIMEOUT, default 7, meaning clocks allowed for mem_busy to rise after a command.
REQ-003 SHALL have ports as follows: clk  in  1  controller clock, same domain as memory controller.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 dsp_req / dsp_ack / dsp_done  in/out/out  1 each  display-fetch requester, read-only.
REQ-006 dsp_addr  in  23  display word address; dsp_rdata  out  32  display read data.
REQ-007 cpu_req / cpu_ack / cpu_done  in/out/out  1 each  VDP port requester.
REQ-008 cpu_we  in  1  write when high; cpu_addr  in  23; cpu_wdata  in  16; cpu_wdata32  in  32; cpu_wdm  in  2.
REQ-009 cpu_rdata  out  16  VDP read data.
REQ-010 mem_read, mem_write, mem_refresh  out  1 each  one-cycle command strobes to the memory controller.
REQ-011 mem_addr  out  23; mem_din  out  16; mem_din32  out  32; mem_wdm  out  2.
REQ-012 mem_dout  in  16; mem_dout32  in  32; mem_busy  in  1.
REQ-013 err_timeout  out  1  sticky; stat_wait_max  out  16  (see Configuration).

Function
REQ-014 States: IDLE, ISSUE, WAIT_START, WAIT_DONE; reset state IDLE.
REQ-015 Refresh counter counts clk up to REFRESH_INTERVAL-1, wraps to 0, sets ref_pend on wrap; ref_pend clears when refresh is granted; a wrap while ref_pend is already set is lost, not queued.
REQ-016 In IDLE with mem_busy low, grant order: display, then ref_pend, then cpu; anti-starvation: after 2 consecutive display grants with cpu_req or ref_pend waiting, the next grant skips display.
REQ-017 Grant: one-cycle ack to the winner, addr/data/wdm latched into mem_* registers, move to ISSUE; refresh has no ack.
REQ-018 ISSUE: exactly one of mem_read/mem_write/mem_refresh high for one cycle; go to WAIT_START.
REQ-019 WAIT_START: on mem_busy high go to WAIT_DONE; after START_TIMEOUT clocks without busy, set err_timeout, pulse done (data 0) and return to IDLE.
REQ-020 WAIT_DONE: on mem_busy low, capture mem_dout/mem_dout32 into cpu_rdata/dsp_rdata (reads only), pulse done for one cycle, go to IDLE.
REQ-021 Minimum grant-to-grant spacing is 4 clocks; req-to-command latency 2 clocks from idle.
REQ-022 Requesters hold req until ack; deasserting req before ack withdraws the request without effect.
REQ-023 cpu_rdata and dsp_rdata hold their value until the next read completion for that requester.
REQ-024 Simultaneous display, cpu and refresh requests produce grants display, refresh, cpu in that order.
REQ-025 No command is issued while mem_busy is high in IDLE.

Reset
REQ-026 Reset asserted at any time: all strobes, ack, done and err_timeout go 0; mem_* and rdata go 0; refresh counter and ref_pend go 0; the starvation counter goes 0; state goes to IDLE. An in-flight operation is abandoned with no done pulse.

Configuration
REQ-027 With VRAM_ARB_STATS_EN defined: stat_wait_max holds the largest number of clocks any cpu_req waited from assertion to ack; the value saturates at 16'hFFFF and clears only on reset.
REQ-028 Without VRAM_ARB_STATS_EN: stat_wait_max is tied to 0 and no counter logic is synthesised.

Verification
REQ-029 cpu_req with we=1, addr=0x000123, wdata=0xA55A, wdm=2'b10, busy rising 1 clock after the command and held 6 clocks -> ack at clk+1, mem_write at clk+2 with matching fields, cpu_done once.
REQ-030 dsp_req, cpu_req and ref_pend all together -> mem_read(dsp), mem_refresh, mem_read/write(cpu) in that order, with no overlap.
REQ-031 dsp_req held continuously while cpu_req is waiting -> cpu granted after 2 display grants.
REQ-032 mem_busy never rises -> err_timeout=1 and done pulse exactly 7 clocks after the command, then the next request is served.
REQ-033 REFRESH_INTERVAL=16 with no other traffic -> mem_refresh every 16 clocks.
REQ-034 Reset mid-WAIT_DONE -> no done pulse, all outputs 0; with STATS_EN, a cpu wait of 9 clocks -> stat_wait_max=9.

Source files
------------

// File: rtl/vram_arbiter.sv
// Arbitrates display fetch, refresh and VDP cpu access onto one VRAM controller port.
// Define VRAM_ARB_STATS_EN to build the cpu worst-case wait tracker on stat_wait_max.
module vram_arbiter #(
  parameter int REFRESH_INTERVAL = 1620,
  parameter int START_TIMEOUT    = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dsp_req,
  output logic        dsp_ack,
  output logic        dsp_done,
  input  logic [22:0] dsp_addr,
  output logic [31:0] dsp_rdata,
  input  logic        cpu_req,
  output logic        cpu_ack,
  output logic        cpu_done,
  input  logic        cpu_we,
  input  logic [22:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  input  logic [31:0] cpu_wdata32,
  input  logic [1:0]  cpu_wdm,
  output logic [15:0] cpu_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_refresh,
  output logic [22:0] mem_addr,
  output logic [15:0] mem_din,
  output logic [31:0] mem_din32,
  output logic [1:0]  mem_wdm,
  input  logic [15:0] mem_dout,
  input  logic [31:0] mem_dout32,
  input  logic        mem_busy,
  output logic        err_timeout,
  output logic [15:0] stat_wait_max
);

  localparam int RW = $clog2(REFRESH_INTERVAL + 1);
  localparam int TW = $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE, S_ISSUE, S_WAIT_START, S_WAIT_DONE
  } state_t;

  typedef enum logic [1:0] {
    O_DSP, O_CPU, O_REF
  } owner_t;

  state_t      r_state;
  owner_t      r_owner;
  logic        r_is_rd;
  logic [TW-1:0] r_to_cnt;
  logic [RW-1:0] r_ref_cnt;
  logic        r_ref_pend;
  logic [1:0]  r_streak;
  logic        r_dsp_ack, r_cpu_ack;
  logic        r_dsp_done, r_cpu_done;
  logic        r_rd, r_wr, r_rf;
  logic [22:0] r_addr;
  logic [15:0] r_din;
  logic [31:0] r_din32;
  logic [1:0]  r_wdm;
  logic [31:0] r_dsp_rdata;
  logic [15:0] r_cpu_rdata;
  logic        r_err;

  logic w_idle_ok, w_others, w_skip;
  logic w_g_dsp, w_g_ref, w_g_cpu;
  logic w_wrap, w_fin_ok, w_fin_to, w_fin;

  assign w_idle_ok = (r_state == S_IDLE) && !mem_busy;
  assign w_others  = cpu_req || r_ref_pend;
  // Two back-to-back display grants with others waiting forces one non-display grant
  assign w_skip    = (r_streak == 2'd2) && w_others;
  assign w_g_dsp   = w_idle_ok && dsp_req && !w_skip;
  assign w_g_ref   = w_idle_ok && r_ref_pend && !w_g_dsp;
  assign w_g_cpu   = w_idle_ok && cpu_req && !w_g_dsp && !r_ref_pend;
  assign w_wrap    = (r_ref_cnt == RW'(REFRESH_INTERVAL - 1));
  assign w_fin_ok  = (r_state == S_WAIT_DONE) && !mem_busy;
  assign w_fin_to  = (r_state == S_WAIT_START) && !mem_busy &&
                     (r_to_cnt == TW'(START_TIMEOUT - 1));
  assign w_fin     = w_fin_ok || w_fin_to;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ref_cnt  <= '0;
      r_ref_pend <= 1'b0;
    end else begin
      r_ref_cnt <= w_wrap ? '0 : r_ref_cnt + 1'b1;
      if (w_g_ref)
        r_ref_pend <= 1'b0;
      else if (w_wrap)
        r_ref_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_owner     <= O_DSP;
      r_is_rd     <= 1'b0;
      r_to_cnt    <= '0;
      r_streak    <= 2'd0;
      r_dsp_ack   <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_dsp_done  <= 1'b0;
      r_cpu_done  <= 1'b0;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_rf        <= 1'b0;
      r_addr      <= '0;
      r_din       <= '0;
      r_din32     <= '0;
      r_wdm       <= '0;
      r_dsp_rdata <= '0;
      r_cpu_rdata <= '0;
      r_err       <= 1'b0;
    end else begin
      r_dsp_ack  <= 1'b0;
      r_cpu_ack  <= 1'b0;
      r_dsp_done <= 1'b0;
      r_cpu_done <= 1'b0;
      r_rd       <= 1'b0;
      r_wr       <= 1'b0;
      r_rf       <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_to_cnt <= '0;
          if (w_g_dsp) begin
            r_dsp_ack <= 1'b1;
            r_owner   <= O_DSP;
            r_is_rd   <= 1'b1;
            r_addr    <= dsp_addr;
            r_din     <= '0;
            r_din32   <= '0;
            r_wdm     <= '0;
            r_streak  <= w_others ? r_streak + 2'd1 : 2'd0;
            r_state   <= S_ISSUE;
          end else if (w_g_ref) begin
            r_owner  <= O_REF;
            r_is_rd  <= 1'b0;
            r_addr   <= '0;
            r_din    <= '0;
            r_din32  <= '0;
            r_wdm    <= '0;
            r_streak <= 2'd0;
            r_state  <= S_ISSUE;
          end else if (w_g_cpu) begin
            r_cpu_ack <= 1'b1;
            r_owner   <= O_CPU;
            r_is_rd   <= !cpu_we;
            r_addr    <= cpu_addr;
            r_din     <= cpu_wdata;
            r_din32   <= cpu_wdata32;
            r_wdm     <= cpu_wdm;
            r_streak  <= 2'd0;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_rf    <= (r_owner == O_REF);
          r_rd    <= (r_owner != O_REF) && r_is_rd;
          r_wr    <= (r_owner == O_CPU) && !r_is_rd;
          r_state <= S_WAIT_START;
        end
        S_WAIT_START: begin
          if (mem_busy)
            r_state <= S_WAIT_DONE;
          else if (w_fin_to) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else
            r_to_cnt <= r_to_cnt + 1'b1;
        end
        S_WAIT_DONE: begin
          if (!mem_busy)
            r_state <= S_IDLE;
        end
      endcase
      // A timed-out read completes with zero data
      if (w_fin) begin
        r_dsp_done <= (r_owner == O_DSP);
        r_cpu_done <= (r_owner == O_CPU);
        if (r_is_rd && r_owner == O_DSP)
          r_dsp_rdata <= w_fin_ok ? mem_dout32 : '0;
        if (r_is_rd && r_owner == O_CPU)
          r_cpu_rdata <= w_fin_ok ? mem_dout : '0;
      end
    end
  end

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] r_wait;
  logic [15:0] r_wait_max;
  logic [15:0] w_wait_nx;

  assign w_wait_nx = (r_wait == 16'hFFFF) ? r_wait : r_wait + 16'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait     <= '0;
      r_wait_max <= '0;
    end else begin
      if (w_g_cpu) begin
        r_wait <= '0;
        if (w_wait_nx > r_wait_max)
          r_wait_max <= w_wait_nx;
      end else if (cpu_req && !r_cpu_ack)
        r_wait <= w_wait_nx;
      else
        r_wait <= '0;
    end
  end

  assign stat_wait_max = r_wait_max;
`else
  assign stat_wait_max = 16'h0000;
`endif

  assign dsp_ack     = r_dsp_ack;
  assign dsp_done    = r_dsp_done;
  assign dsp_rdata   = r_dsp_rdata;
  assign cpu_ack     = r_cpu_ack;
  assign cpu_done    = r_cpu_done;
  assign cpu_rdata   = r_cpu_rdata;
  assign mem_read    = r_rd;
  assign mem_write   = r_wr;
  assign mem_refresh = r_rf;
  assign mem_addr    = r_addr;
  assign mem_din     = r_din;
  assign mem_din32   = r_din32;
  assign mem_wdm     = r_wdm;
  assign err_timeout = r_err;

endmodule
